main_mem_ctrl: RTL and testbench

Two-port block-transfer controller for the main memory array: 1,048,576 blocks × 16 words × 32 bits.
- Arbitrates round-robin between two requesters, e.g. requester 0 = I-cache refill, requester 1 = D-cache refill/writeback.
- Models a fixed initial access latency.
- Sequences each granted request as a burst of 16 single-word memory accesses.
- Sits between the cache miss handlers and the memory array's word-access port.

---
 rtl/main_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_main_mem_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - two-requester round-robin block-transfer controller for the main memory array
module main_mem_ctrl #(
  parameter int BLOCKS     = 1048576,
  parameter int WORDS      = 16,
  parameter int WORD_W     = 32,
  parameter int ACCESS_LAT = 4,
  parameter int BLK_W      = $clog2(BLOCKS),
  parameter int BEAT_W     = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*BLK_W-1:0]    blk,
  input  logic [2*WORD_W-1:0]   wdata,
  output logic [1:0]            gnt,
  output logic [BEAT_W-1:0]     beat,
  output logic [1:0]            rvalid,
  output logic [WORD_W-1:0]     rdata,
  output logic [BEAT_W-1:0]     rword,
  output logic [1:0]            done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [BLK_W-1:0]      mem_blk,
  output logic [BEAT_W-1:0]     mem_word,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata
);

  // Latency counter only needs to hold ACCESS_LAT-1; keep at least one bit.
  localparam int LAT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_t;

  state_t             state;
  logic               owner;
  logic               last_owner;
  logic               we_q;
  logic [BLK_W-1:0]   blk_q;
  logic [LAT_W-1:0]   lat_cnt;
  logic [WORD_W-1:0]  rdata_q;
  logic               win;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not own last.
  always_comb begin
    win = req[1];
    if (req == 2'b11) begin
      win = ~last_owner;
    end
  end

  // Transaction sequencer: grant, access latency, 16-beat burst, completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      blk_q      <= '0;
      lat_cnt    <= '0;
      beat       <= '0;
      gnt        <= '0;
      done       <= '0;
      rvalid     <= '0;
      rword      <= '0;
      mem_en     <= 1'b0;
    end else begin
      gnt    <= '0;
      done   <= '0;
      rvalid <= '0;
      rword  <= beat;
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner      <= win;
            last_owner <= win;
            we_q       <= we[win];
            blk_q      <= win ? blk[2*BLK_W-1:BLK_W] : blk[BLK_W-1:0];
            lat_cnt    <= LAT_W'(ACCESS_LAT - 1);
            gnt[win]   <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            beat   <= '0;
            mem_en <= 1'b1;
            state  <= S_XFER;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_XFER: begin
          rvalid[owner] <= ~we_q;
          if (beat == BEAT_W'(WORDS - 1)) begin
            beat        <= '0;
            mem_en      <= 1'b0;
            done[owner] <= 1'b1;
            state       <= S_DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Keep the last delivered read word so rdata is stable between read beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (|rvalid) begin
      rdata_q <= mem_rdata;
    end
  end

  assign rdata     = (|rvalid) ? mem_rdata : rdata_q;
  assign mem_we    = mem_en & we_q;
  assign mem_blk   = mem_en ? blk_q : '0;
  assign mem_word  = beat;
  assign mem_wdata = mem_we ? (owner ? wdata[2*WORD_W-1:WORD_W] : wdata[WORD_W-1:0]) : '0;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - directed bench with a schedule-level reference model for main_mem_ctrl
module tb_main_mem_ctrl;

  localparam int BLK_W  = 20;
  localparam int WORD_W = 32;
  localparam int LAT    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*BLK_W-1:0]  blk;
  logic [2*WORD_W-1:0] wdata;
  logic [1:0]          gnt;
  logic [3:0]          beat;
  logic [1:0]          rvalid;
  logic [31:0]         rdata;
  logic [3:0]          rword;
  logic [1:0]          done;
  logic                mem_en;
  logic                mem_we;
  logic [19:0]         mem_blk;
  logic [3:0]          mem_word;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata;
  logic [31:0]         pat0;
  logic [31:0]         pat1;

  // Requesters present word[beat] combinationally
  assign wdata = {pat1 + {28'd0, beat}, pat0 + {28'd0, beat}};

  main_mem_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .blk(blk), .wdata(wdata),
    .gnt(gnt), .beat(beat), .rvalid(rvalid), .rdata(rdata), .rword(rword), .done(done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_blk(mem_blk), .mem_word(mem_word),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Second instance with minimum latency
  logic                rst_l = 1'b1;
  logic [1:0]          req_l;
  logic [1:0]          gnt_l;
  logic [3:0]          beat_l;
  logic [1:0]          rvalid_l;
  logic [31:0]         rdata_l;
  logic [3:0]          rword_l;
  logic [1:0]          done_l;
  logic                mem_en_l;
  logic                mem_we_l;
  logic [19:0]         mem_blk_l;
  logic [3:0]          mem_word_l;
  logic [31:0]         mem_wdata_l;

  main_mem_ctrl #(.ACCESS_LAT(1)) dut_l (
    .clk(clk), .rst(rst_l), .req(req_l), .we(2'b00), .blk(40'd0), .wdata(64'd0),
    .gnt(gnt_l), .beat(beat_l), .rvalid(rvalid_l), .rdata(rdata_l), .rword(rword_l), .done(done_l),
    .mem_en(mem_en_l), .mem_we(mem_we_l), .mem_blk(mem_blk_l), .mem_word(mem_word_l),
    .mem_wdata(mem_wdata_l), .mem_rdata(32'd0)
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory array the controller talks to
  logic [31:0] env_mem [logic [23:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[{mem_blk, mem_word}] = mem_wdata;
    if (mem_en && !mem_we)
      mem_rdata <= env_mem.exists({mem_blk, mem_word}) ? env_mem[{mem_blk, mem_word}] : 32'd0;
    else
      mem_rdata <= 32'hDEADBEEF;
  end

  // Reference model: transaction schedule derived from grant cycle
  logic [31:0] ref_mem [logic [23:0]];
  int          cyc;
  bit          m_act;
  int          m_g;
  bit          m_own;
  bit          m_we;
  bit          m_last;
  logic [19:0] m_blk;
  logic [31:0] m_rhold;
  logic [1:0]  e_gnt = '0, e_rvalid = '0, e_done = '0;
  logic [3:0]  e_beat = '0, e_rword = '0, e_word = '0;
  logic [31:0] e_rdata = '0, e_wdata = '0;
  logic        e_en = 1'b0, e_we = 1'b0;
  logic [19:0] e_blk = '0;

  always @(posedge clk or posedge rst) begin
    int off;
    bit xfer;
    bit rd;
    if (rst) begin
      cyc = 0; m_act = 0; m_last = 1; m_g = 0; m_rhold = '0;
      e_gnt = '0; e_rvalid = '0; e_done = '0; e_beat = '0; e_rword = '0; e_word = '0;
      e_rdata = '0; e_wdata = '0; e_en = 1'b0; e_we = 1'b0; e_blk = '0;
    end else begin
      if ((!m_act || cyc >= m_g + LAT + 17) && req != 2'b00) begin
        m_own  = (req == 2'b11) ? !m_last : req[1];
        m_last = m_own;
        m_act  = 1;
        m_g    = cyc + 1;
        m_we   = we[m_own];
        m_blk  = m_own ? blk[39:20] : blk[19:0];
      end
      cyc  = cyc + 1;
      off  = m_act ? cyc - m_g : -1;
      xfer = m_act && off >= LAT && off <= LAT + 15;
      rd   = m_act && off >= LAT + 1 && off <= LAT + 16;
      e_gnt  = (m_act && off == 0) ? (2'b01 << m_own) : 2'b00;
      e_done = (m_act && off == LAT + 16) ? (2'b01 << m_own) : 2'b00;
      e_en   = xfer;
      e_beat = xfer ? 4'(off - LAT) : 4'd0;
      e_word = e_beat;
      e_blk  = xfer ? m_blk : 20'd0;
      e_we   = xfer && m_we;
      e_wdata = e_we ? ((m_own ? pat1 : pat0) + {28'd0, e_beat}) : 32'd0;
      if (e_we) ref_mem[{m_blk, e_beat}] = e_wdata;
      e_rword  = rd ? 4'(off - LAT - 1) : 4'd0;
      e_rvalid = (rd && !m_we) ? (2'b01 << m_own) : 2'b00;
      if (e_rvalid != 2'b00)
        m_rhold = ref_mem.exists({m_blk, e_rword}) ? ref_mem[{m_blk, e_rword}] : 32'd0;
      e_rdata = m_rhold;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event log for the directed checks
  int          g0_q[$];
  int          g1_q[$];
  int          en_first, en_last, we_cnt, rv_first, rv_last, rv_cnt, done_cyc, done_cnt;
  logic [31:0] rd_log [16];

  task automatic clear_log();
    g0_q.delete(); g1_q.delete();
    en_first = -1; en_last = -1; we_cnt = 0; rv_first = -1; rv_last = -1;
    rv_cnt = 0; done_cyc = -1; done_cnt = 0;
    for (int k = 0; k < 16; k++) rd_log[k] = '0;
  endtask

  // Per-cycle compare against the model, plus event logging
  always @(posedge clk) begin
    #2;
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("beat", 64'(beat), 64'(e_beat));
    chk("rvalid", 64'(rvalid), 64'(e_rvalid));
    chk("rdata", 64'(rdata), 64'(e_rdata));
    chk("rword", 64'(rword), 64'(e_rword));
    chk("done", 64'(done), 64'(e_done));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_blk", 64'(mem_blk), 64'(e_blk));
    chk("mem_word", 64'(mem_word), 64'(e_word));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    if (!rst) begin
      if (gnt[0]) g0_q.push_back(cyc);
      if (gnt[1]) g1_q.push_back(cyc);
      if (mem_en) begin
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
        if (mem_we) we_cnt++;
      end
      if (|rvalid) begin
        if (rv_first < 0) rv_first = cyc;
        rv_last = cyc;
        rv_cnt++;
        rd_log[rword] = rdata;
      end
      if (|done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  // Log for the minimum-latency instance
  int cyc_l;
  int l_en_first = -1;
  int l_done_first = -1;
  int gl_q[$];
  always @(posedge clk) begin
    if (rst_l) cyc_l = 0;
    else cyc_l = cyc_l + 1;
  end
  always @(posedge clk) begin
    #2;
    if (!rst_l) begin
      if (mem_en_l && l_en_first < 0) l_en_first = cyc_l;
      if (|done_l && l_done_first < 0) l_done_first = cyc_l;
      if (gnt_l[0]) gl_q.push_back(cyc_l);
    end
  end

  task automatic wait_ev(input int sel, input int budget, input string name);
    int  n = 0;
    bit  hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (sel)
        0: hit = gnt[0];
        1: hit = gnt[1];
        2: hit = done[0];
        default: hit = done[1];
      endcase
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout %s: no event within %0d cycles", name, budget);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Read of blk 5 starting at c0 = 0 (reset-relative)
  task automatic check_case1(input string tag);
    chk({tag, " gnt count"}, 64'(g0_q.size()), 64'd1);
    chk({tag, " gnt cycle"}, 64'(g0_q.size() > 0 ? g0_q[0] : -1), 64'd1);
    chk({tag, " first mem_en"}, 64'(en_first), 64'd5);
    chk({tag, " last mem_en"}, 64'(en_last), 64'd20);
    chk({tag, " first rvalid"}, 64'(rv_first), 64'd6);
    chk({tag, " last rvalid"}, 64'(rv_last), 64'd21);
    chk({tag, " rvalid count"}, 64'(rv_cnt), 64'd16);
    chk({tag, " done cycle"}, 64'(done_cyc), 64'd21);
    for (int k = 0; k < 16; k++) chk({tag, " rdata word"}, 64'(rd_log[k]), 64'(32'h500 + k));
  endtask

  initial begin
    int base;
    int n;
    int dc;
    req = '0; we = '0; blk = '0; pat0 = 32'h5000_0000; pat1 = 32'h0; req_l = '0;
    for (int k = 0; k < 16; k++) begin
      env_mem[{20'h00005, 4'(k)}] = 32'h500 + k;
      ref_mem[{20'h00005, 4'(k)}] = 32'h500 + k;
    end
    clear_log();
    idle(2);

    // Single read, plus the ACCESS_LAT = 1 instance with a continuous request
    blk[19:0] = 20'h00005; we = 2'b00; req = 2'b01; req_l = 2'b01;
    rst = 1'b0; rst_l = 1'b0;
    wait_ev(0, 10, "t1 gnt0");
    req[0] = 1'b0;
    wait_ev(2, 40, "t1 done0");
    check_case1("t1");
    while (cyc_l < 45) @(negedge clk);
    req_l = 2'b00;
    chk("lat1 first mem_en", 64'(l_en_first), 64'd2);
    chk("lat1 done cycle", 64'(l_done_first), 64'd18);
    chk("lat1 gnt0", 64'(gl_q.size() > 0 ? gl_q[0] : -1), 64'd1);
    chk("lat1 gnt1", 64'(gl_q.size() > 1 ? gl_q[1] : -1), 64'd20);
    chk("lat1 gnt2", 64'(gl_q.size() > 2 ? gl_q[2] : -1), 64'd39);

    // Block write to 0xFFFFF by requester 1, then read it back
    idle(2);
    clear_log();
    pat1 = 32'hA000_0000; blk[39:20] = 20'hFFFFF; we = 2'b10; req = 2'b10;
    wait_ev(1, 10, "t2 gnt1");
    req = 2'b00;
    wait_ev(3, 40, "t2 done1");
    chk("t2 write beats", 64'(we_cnt), 64'd16);
    chk("t2 burst span", 64'(en_last - en_first), 64'd15);
    chk("t2 rvalid on write", 64'(rv_cnt), 64'd0);
    idle(2);
    clear_log();
    we = 2'b00; req = 2'b10;
    wait_ev(1, 10, "t2r gnt1");
    req = 2'b00;
    wait_ev(3, 40, "t2r done1");
    chk("t2r rvalid count", 64'(rv_cnt), 64'd16);
    for (int k = 0; k < 16; k++) chk("t2r rdata word", 64'(rd_log[k]), 64'(32'hA000_0000 + k));

    // Request from requester 1 while requester 0 is busy
    idle(2);
    clear_log();
    base = cyc;
    blk[19:0] = 20'h00005; req = 2'b01;
    wait_ev(0, 10, "t4 gnt0");
    req[0] = 1'b0;
    while (cyc < base + 10) @(negedge clk);
    req[1] = 1'b1;
    wait_ev(1, 30, "t4 gnt1");
    req[1] = 1'b0;
    wait_ev(3, 40, "t4 done1");
    chk("t4 gnt0 cycle", 64'(g0_q.size() > 0 ? g0_q[0] - base : -1), 64'd1);
    chk("t4 gnt1 count", 64'(g1_q.size()), 64'd1);
    chk("t4 gnt1 cycle", 64'(g1_q.size() > 0 ? g1_q[0] - base : -1), 64'd23);
    chk("t4 done count", 64'(done_cnt), 64'd2);
    chk("t4 rvalid count", 64'(rv_cnt), 64'd32);

    // Both requests held from reset: alternating grants
    @(negedge clk);
    rst = 1'b1;
    req = 2'b11; we = 2'b00; blk = {20'hFFFFF, 20'h00005};
    clear_log();
    @(negedge clk);
    rst = 1'b0;
    while (cyc < 70) @(negedge clk);
    req = 2'b00;
    wait_ev(3, 40, "t3 last done1");
    chk("t3 gnt0 count", 64'(g0_q.size()), 64'd2);
    chk("t3 gnt1 count", 64'(g1_q.size()), 64'd2);
    chk("t3 gnt0 first", 64'(g0_q.size() > 0 ? g0_q[0] : -1), 64'd1);
    chk("t3 gnt1 first", 64'(g1_q.size() > 0 ? g1_q[0] : -1), 64'd23);
    chk("t3 gnt0 second", 64'(g0_q.size() > 1 ? g0_q[1] : -1), 64'd45);
    chk("t3 gnt1 second", 64'(g1_q.size() > 1 ? g1_q[1] : -1), 64'd67);

    // Reset in the middle of a read burst
    idle(2);
    clear_log();
    base = cyc;
    blk[19:0] = 20'h00005; req = 2'b01;
    wait_ev(0, 10, "t5 gnt0");
    req = 2'b00;
    n = 0;
    while (beat != 4'd7 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t5 beat7 cycle", 64'(cyc - base), 64'd12);
    dc = done_cnt;
    rst = 1'b1;
    #1;
    chk("t5 rst gnt", 64'(gnt), 64'd0);
    chk("t5 rst beat", 64'(beat), 64'd0);
    chk("t5 rst rvalid", 64'(rvalid), 64'd0);
    chk("t5 rst rdata", 64'(rdata), 64'd0);
    chk("t5 rst rword", 64'(rword), 64'd0);
    chk("t5 rst done", 64'(done), 64'd0);
    chk("t5 rst mem_en", 64'(mem_en), 64'd0);
    chk("t5 rst mem_we", 64'(mem_we), 64'd0);
    chk("t5 rst mem_blk", 64'(mem_blk), 64'd0);
    chk("t5 rst mem_word", 64'(mem_word), 64'd0);
    chk("t5 rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("t5 no done before rst", 64'(dc), 64'd0);
    idle(2);
    chk("t5 no done in rst", 64'(done_cnt), 64'd0);
    clear_log();
    req = 2'b01;
    rst = 1'b0;
    wait_ev(0, 10, "t5 gnt0 after rst");
    req = 2'b00;
    wait_ev(2, 40, "t5 done0 after rst");
    check_case1("t5");

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
